ifu_fetch_redirect: RTL and testbench
=====================================

Name: ifu_fetch_redirect

Overview:
Fetch-side counterpart of the execute-stage branch/jump unit. It consumes the resolved i_jump_en/i_jump_addr, owns the architectural fetch PC, and issues single-outstanding requests to instruction memory. It squashes wrong-path fetches and holds one fetched instruction for decode in a single-entry buffer. It sits between the instruction bus and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
PC_INC, 4, PC increment per sequential fetch; RV32I only, no compressed instructions.

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  reset, synchronous, active-low
i_jump_en  in  1  one-cycle redirect pulse from execute
i_jump_addr  in  32  redirect target
o_ifetch_req  out  1  fetch request valid
o_ifetch_addr  out  32  fetch address, word aligned
i_ifetch_gnt  in  1  request accepted this cycle
i_ifetch_rvalid  in  1  response valid; at least 1 cycle after gnt
i_ifetch_rdata  in  32  response instruction
o_inst_valid  out  1  buffered instruction valid
o_inst  out  32  buffered instruction
o_inst_pc  out  32  PC of o_inst
i_inst_ready  in  1  decode accepts o_inst
o_flush  out  1  registered squash pulse to decode/execute
o_jump_misalign  out  1  registered pulse: jump target [1:0] != 0

Behaviour:
- One clock, i_clk. Reset is synchronous, active-low: i_rst_n sampled on the rising edge.
- Reset values: state=IDLE, pc=RESET_PC, buffer invalid, all outputs 0. o_ifetch_addr still shows pc.
- States: IDLE, FETCH, WAIT, KILL.
- IDLE: entered only by reset; goes to FETCH on the next cycle.
- FETCH:
  - o_ifetch_req = !o_inst_valid | i_inst_ready (buffer free, or draining this cycle); o_ifetch_addr = pc.
  - On req&gnt: pend_pc<=pc, pc<=pc+PC_INC, go to WAIT.
  - While not granted, the address may change; the bus permits this.
- WAIT:
  - req=0.
  - On rvalid: buffer<= {1, rdata, pend_pc}, go to FETCH.
  - Space is guaranteed by the FETCH issue rule.
- KILL:
  - req=0.
  - On rvalid: discard the response, go to FETCH.
- Buffer: cleared when o_inst_valid&i_inst_ready, unless refilled on the same edge. Fill and drain may occur together.
- Redirect on i_jump_en (priority over every other event):
  - pc <= {i_jump_addr[31:2],2'b00}.
  - Buffer invalidated on the same edge; a concurrent rvalid is never written.
  - o_flush=1 the next cycle, for exactly 1 cycle.
  - o_jump_misalign=1 the next cycle if i_jump_addr[1:0]!=0.
  - FETCH without gnt: stay FETCH; the next request uses the target.
  - FETCH with gnt: go to KILL; that grant was to the old pc.
  - WAIT without rvalid: go to KILL.
  - WAIT with rvalid: discard, go to FETCH.
  - KILL without rvalid: stay KILL, pc updated.
  - KILL with rvalid: go to FETCH.
  - IDLE: pc updated, go to FETCH.
- Back-to-back jumps on consecutive cycles: the last target wins; o_flush stays high for each.
- At most one outstanding bus transaction at all times.
- pc+PC_INC wraps modulo 2^32.
- Reset mid-transaction: state returns to IDLE. The bus is reset by the same i_rst_n, so no stale response arrives.
- Sequential throughput: 1 instruction per 2 cycles minimum (request cycle + response cycle).

Decomposition:
- Shared package (core defines): fetch state encoding (IDLE/FETCH/WAIT/KILL), RESET_PC default, PC_INC, instruction width 32.
- Sub-module ifu_inst_buf: single-entry valid/data/pc register with fill, drain and flush inputs; outputs o_inst_valid/o_inst/o_inst_pc.

Test Plan:
- Reset release, RESET_PC=0, gnt same cycle, rvalid next cycle -> fetch addresses 0x0, 0x4, 0x8; o_inst_pc matches; o_flush stays 0.
- Decode stall: i_inst_ready=0 with buffer holding 0x4 -> o_ifetch_req=0 until ready. No overwrite; o_inst is stable.
- Jump to 0x100 while WAIT on fetch of 0x8 -> KILL; the rvalid data is dropped; next request is 0x100; o_flush is a single pulse; o_inst_valid=0 until data for 0x100 returns.
- i_jump_en with i_ifetch_gnt in the same cycle (fetch 0xC, target 0x40) -> KILL; the 0xC response is discarded; next address is 0x40.
- i_jump_en with i_ifetch_rvalid in the same cycle -> response not buffered; the next request goes to the target with no KILL state.
- Jump to 0x202 -> fetch 0x200; o_jump_misalign pulses 1 cycle.
- Assert i_rst_n=0 during WAIT -> outputs zero next edge; after release, first request is RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_redirect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_redirect_pkg
// Description : Shared fetch-unit definitions. Fetch state encoding, default
//               reset PC, sequential PC step and instruction width.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_fetch_redirect_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned INST_W           = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC_DEFAULT   = 4;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_e;

  // Force a redirect target onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage : ifu_fetch_redirect_pkg
`default_nettype wire

// File: rtl/ifu_inst_buf.sv
`default_nettype none
// ============================================================================
// Module      : ifu_inst_buf
// Description : Single-entry instruction buffer between fetch and decode.
//               Flush beats fill, fill beats drain, so a refill on the
//               draining edge keeps the entry valid.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_inst_buf
  import ifu_fetch_redirect_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fill,
  input  logic              i_drain,
  input  logic              i_flush,
  input  logic [INST_W-1:0] i_inst,
  input  logic [XLEN-1:0]   i_pc,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [XLEN-1:0]   o_inst_pc
);

  logic              valid_q;
  logic [INST_W-1:0] inst_q;
  logic [XLEN-1:0]   pc_q;

  // Entry update: flush has priority, then fill, then drain
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (i_fill) begin
      valid_q <= 1'b1;
      inst_q  <= i_inst;
      pc_q    <= i_pc;
    end else if (i_drain) begin
      valid_q <= 1'b0;
    end
  end

  assign o_inst_valid = valid_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = pc_q;

endmodule : ifu_inst_buf
`default_nettype wire

// File: rtl/ifu_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_redirect
// Description : Fetch PC owner. Issues single-outstanding instruction bus
//               requests, squashes wrong-path responses after a redirect
//               from execute and buffers one instruction for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_redirect
  import ifu_fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_INC   = PC_INC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_jump_en,
  input  logic [31:0] i_jump_addr,
  output logic        o_ifetch_req,
  output logic [31:0] o_ifetch_addr,
  input  logic        i_ifetch_gnt,
  input  logic        i_ifetch_rvalid,
  input  logic [31:0] i_ifetch_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_flush,
  output logic        o_jump_misalign
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            flush_q;
  logic            misalign_q;

  logic buf_fill;
  logic buf_drain;

  // A request only goes out when the buffer will have room for its response,
  // which is what keeps the WAIT-state fill from ever overwriting.
  assign o_ifetch_req  = (state_q == ST_FETCH) && (!o_inst_valid || i_inst_ready);
  assign o_ifetch_addr = pc_q;

  // A response landing on a redirect edge belongs to the old path
  assign buf_fill  = (state_q == ST_WAIT) && i_ifetch_rvalid && !i_jump_en;
  assign buf_drain = o_inst_valid && i_inst_ready;

  // Fetch FSM, PC tracking and registered redirect pulses
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      flush_q    <= i_jump_en;
      misalign_q <= i_jump_en && (i_jump_addr[1:0] != 2'b00);
      if (i_jump_en) begin
        pc_q <= word_align(i_jump_addr);
        case (state_q)
          ST_IDLE:  state_q <= ST_FETCH;
          // A grant on the redirect edge was for the old PC; its response must be dropped
          ST_FETCH: state_q <= (o_ifetch_req && i_ifetch_gnt) ? ST_KILL : ST_FETCH;
          ST_WAIT:  state_q <= i_ifetch_rvalid ? ST_FETCH : ST_KILL;
          ST_KILL:  state_q <= i_ifetch_rvalid ? ST_FETCH : ST_KILL;
          default:  state_q <= ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_FETCH;
          ST_FETCH: begin
            if (o_ifetch_req && i_ifetch_gnt) begin
              pend_pc_q <= pc_q;
              pc_q      <= pc_q + PC_STEP;
              state_q   <= ST_WAIT;
            end
          end
          ST_WAIT: if (i_ifetch_rvalid) state_q <= ST_FETCH;
          ST_KILL: if (i_ifetch_rvalid) state_q <= ST_FETCH;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_flush         = flush_q;
  assign o_jump_misalign = misalign_q;

  ifu_inst_buf u_inst_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_fill       (buf_fill),
    .i_drain      (buf_drain),
    .i_flush      (i_jump_en),
    .i_inst       (i_ifetch_rdata),
    .i_pc         (pend_pc_q),
    .o_inst_valid (o_inst_valid),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc)
  );

endmodule : ifu_fetch_redirect
`default_nettype wire

// File: tb/tb_ifu_fetch_redirect.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch_redirect
// Description : Directed self-checking bench for ifu_fetch_redirect with a
//               scoreboard of instructions expected at the decode port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_redirect;

  logic        clk;
  logic        rst_n;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        ready;
  logic        flush;
  logic        misalign;

  int errs   = 0;
  int checks = 0;

  // Scoreboard entries: {pc, instruction}
  logic [63:0] sb_q[$];

  ifu_fetch_redirect dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_jump_en       (jump_en),
    .i_jump_addr     (jump_addr),
    .o_ifetch_req    (req),
    .o_ifetch_addr   (addr),
    .i_ifetch_gnt    (gnt),
    .i_ifetch_rvalid (rvalid),
    .i_ifetch_rdata  (rdata),
    .o_inst_valid    (inst_valid),
    .o_inst          (inst),
    .o_inst_pc       (inst_pc),
    .i_inst_ready    (ready),
    .o_flush         (flush),
    .o_jump_misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle
  task automatic set_in(input logic j, input logic [31:0] ja, input logic g,
                        input logic rv, input logic [31:0] rd, input logic rdy);
    jump_en   = j;
    jump_addr = ja;
    gnt       = g;
    rvalid    = rv;
    rdata     = rd;
    ready     = rdy;
    #1;
  endtask

  // Compare any instruction decode accepts this cycle, then advance one clock
  task automatic tick();
    logic [63:0] e;
    if (rst_n && inst_valid && ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_accept", inst_pc, 32'hDEAD_DEAD);
      end else begin
        e = sb_q.pop_front();
        chk("sb_inst_pc", inst_pc, e[63:32]);
        chk("sb_inst", inst, e[31:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    tick();
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 0);
    chk("rst_flush", {31'd0, flush}, 0);
    chk("rst_misalign", {31'd0, misalign}, 0);

    // Sequential fetch from RESET_PC
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 1);
    chk("idle_req", {31'd0, req}, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 1);
    chk("f0_req", {31'd0, req}, 1);
    chk("f0_addr", addr, 32'h0);
    tick();
    set_in(0, 0, 0, 1, mem(32'h0), 1);
    sb_q.push_back({32'h0, mem(32'h0)});
    chk("w0_req", {31'd0, req}, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 1);
    chk("f4_valid", {31'd0, inst_valid}, 1);
    chk("f4_addr", addr, 32'h4);
    chk("f4_req", {31'd0, req}, 1);
    tick();
    set_in(0, 0, 0, 1, mem(32'h4), 1);
    sb_q.push_back({32'h4, mem(32'h4)});
    tick();

    // Decode stall holding 0x4
    set_in(0, 0, 1, 0, 0, 0);
    chk("stall_req0", {31'd0, req}, 0);
    chk("stall_pc0", inst_pc, 32'h4);
    tick();
    set_in(0, 0, 1, 0, 0, 0);
    chk("stall_req1", {31'd0, req}, 0);
    chk("stall_inst1", inst, mem(32'h4));
    chk("stall_no_flush", {31'd0, flush}, 0);
    tick();
    set_in(0, 0, 1, 0, 0, 1);
    chk("f8_req", {31'd0, req}, 1);
    chk("f8_addr", addr, 32'h8);
    tick();

    // Redirect to 0x100 while waiting on 0x8
    set_in(1, 32'h100, 0, 0, 0, 1);
    chk("wj_req", {31'd0, req}, 0);
    tick();
    chk("kill_flush", {31'd0, flush}, 1);
    chk("kill_misalign", {31'd0, misalign}, 0);
    set_in(0, 0, 1, 1, mem(32'h8), 1);
    chk("kill_req", {31'd0, req}, 0);
    tick();
    chk("kill_flush_end", {31'd0, flush}, 0);
    chk("kill_dropped", {31'd0, inst_valid}, 0);
    set_in(0, 0, 1, 0, 0, 1);
    chk("f100_req", {31'd0, req}, 1);
    chk("f100_addr", addr, 32'h100);
    tick();
    set_in(0, 0, 0, 1, mem(32'h100), 1);
    sb_q.push_back({32'h100, mem(32'h100)});
    tick();

    // Redirect to 0x40 on the same edge as a grant for 0x104
    set_in(1, 32'h40, 1, 0, 0, 1);
    chk("fj_addr", addr, 32'h104);
    chk("fj_req", {31'd0, req}, 1);
    tick();
    chk("fj_flush", {31'd0, flush}, 1);
    chk("fj_buf_clear", {31'd0, inst_valid}, 0);
    set_in(0, 0, 0, 1, mem(32'h104), 1);
    chk("fj_kill_req", {31'd0, req}, 0);
    tick();
    chk("fj_dropped", {31'd0, inst_valid}, 0);
    set_in(0, 0, 1, 0, 0, 1);
    chk("f40_addr", addr, 32'h40);
    chk("f40_req", {31'd0, req}, 1);
    tick();

    // Redirect to misaligned 0x202 on the same edge as rvalid
    set_in(1, 32'h202, 0, 1, mem(32'h40), 1);
    tick();
    chk("rj_not_buffered", {31'd0, inst_valid}, 0);
    chk("rj_flush", {31'd0, flush}, 1);
    chk("rj_misalign", {31'd0, misalign}, 1);
    set_in(0, 0, 0, 0, 0, 1);
    chk("rj_req_no_kill", {31'd0, req}, 1);
    chk("rj_addr", addr, 32'h200);
    tick();
    chk("rj_flush_end", {31'd0, flush}, 0);
    chk("rj_misalign_end", {31'd0, misalign}, 0);
    chk("rj_addr_hold", addr, 32'h200);

    // Back-to-back redirects: last target wins
    set_in(1, 32'h300, 0, 0, 0, 1);
    tick();
    chk("bb_flush0", {31'd0, flush}, 1);
    set_in(1, 32'h400, 0, 0, 0, 1);
    tick();
    chk("bb_flush1", {31'd0, flush}, 1);
    chk("bb_addr", addr, 32'h400);
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    chk("bb_flush_end", {31'd0, flush}, 0);

    // PC wrap past 0xFFFFFFFC
    set_in(1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 1, 0, 0, 1);
    chk("wrap_addr0", addr, 32'hFFFF_FFFC);
    tick();
    set_in(0, 0, 0, 1, mem(32'hFFFF_FFFC), 1);
    sb_q.push_back({32'hFFFF_FFFC, mem(32'hFFFF_FFFC)});
    tick();
    set_in(0, 0, 1, 0, 0, 1);
    chk("wrap_addr1", addr, 32'h0);
    tick();

    // Reset while waiting on a response
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    chk("mrst_req", {31'd0, req}, 0);
    chk("mrst_addr", addr, 32'h0);
    chk("mrst_valid", {31'd0, inst_valid}, 0);
    chk("mrst_flush", {31'd0, flush}, 0);
    rst_n = 1'b1;
    tick();
    set_in(0, 0, 1, 0, 0, 1);
    chk("mrst_first_req", {31'd0, req}, 1);
    chk("mrst_first_addr", addr, 32'h0);
    tick();
    set_in(0, 0, 0, 1, mem(32'h0), 1);
    sb_q.push_back({32'h0, mem(32'h0)});
    tick();
    set_in(0, 0, 0, 0, 0, 1);
    tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_ifu_fetch_redirect
`default_nettype wire
